// File: rtl/sc_statemachine_frogmove_if.sv
// ----------------------------------------------------------------------------
// sc_statemachine_frogmove_if : button/collision inputs and position-register
// commands of the frog-move FSM.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sc_statemachine_frogmove_if #(
  parameter int DATAWIDTH = 8
);
  logic                 SC_FrogMove_start_InLow;
  logic                 SC_FrogMove_left_InLow;
  logic                 SC_FrogMove_right_InLow;
  logic                 SC_FrogMove_collision_InLow;
  logic [DATAWIDTH-1:0] SC_FrogMove_frogPos_InBUS;
  logic                 SC_FrogMove_clear_OutLow;
  logic                 SC_FrogMove_load0_OutLow;
  logic [1:0]           SC_FrogMove_shiftselection_Out;
  logic                 SC_FrogMove_clearLOST_OutLow;
  logic [1:0]           SC_FrogMove_lives_OutBUS;

  // master: buttons and datapath side; slave: the FSM
  modport master (
    output SC_FrogMove_start_InLow, SC_FrogMove_left_InLow, SC_FrogMove_right_InLow,
           SC_FrogMove_collision_InLow, SC_FrogMove_frogPos_InBUS,
    input  SC_FrogMove_clear_OutLow, SC_FrogMove_load0_OutLow,
           SC_FrogMove_shiftselection_Out, SC_FrogMove_clearLOST_OutLow,
           SC_FrogMove_lives_OutBUS
  );

  modport slave (
    input  SC_FrogMove_start_InLow, SC_FrogMove_left_InLow, SC_FrogMove_right_InLow,
           SC_FrogMove_collision_InLow, SC_FrogMove_frogPos_InBUS,
    output SC_FrogMove_clear_OutLow, SC_FrogMove_load0_OutLow,
           SC_FrogMove_shiftselection_Out, SC_FrogMove_clearLOST_OutLow,
           SC_FrogMove_lives_OutBUS
  );
endinterface

`default_nettype wire

// File: rtl/sc_statemachine_frogmove.sv
// ----------------------------------------------------------------------------
// sc_statemachine_frogmove : Moore FSM issuing one-cycle commands to the frog
// position register, with move cooldown and lives tracking.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sc_statemachine_frogmove #(
  parameter int DATAWIDTH       = 8,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int LIVES_INIT      = 3
) (
  input  logic                       SC_RegPOINTTYPE_CLOCK_50,
  input  logic                       SC_RegPOINTTYPE_RESET_InHigh,
  sc_statemachine_frogmove_if.slave  bus
);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_MOVE_L = 3'd2;
  localparam logic [2:0] ST_MOVE_R = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_HIT    = 3'd5;
  localparam logic [2:0] ST_LOST   = 3'd6;

  localparam int             CNT_W    = $clog2(COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [1:0]     LIVES_RST = 2'(LIVES_INIT);

  localparam logic [DATAWIDTH-1:0] MSB_MASK = {1'b1, {(DATAWIDTH-1){1'b0}}};
  localparam logic [DATAWIDTH-1:0] LSB_MASK = {{(DATAWIDTH-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [1:0]       lives;
  logic [CNT_W-1:0] cnt;

  logic start_n, left_n, right_n, coll_n;
  logic at_msb, at_lsb, cool_done;

  assign start_n   = bus.SC_FrogMove_start_InLow;
  assign left_n    = bus.SC_FrogMove_left_InLow;
  assign right_n   = bus.SC_FrogMove_right_InLow;
  assign coll_n    = bus.SC_FrogMove_collision_InLow;
  assign at_msb    = (bus.SC_FrogMove_frogPos_InBUS & MSB_MASK) != '0;
  assign at_lsb    = (bus.SC_FrogMove_frogPos_InBUS & LSB_MASK) != '0;
  assign cool_done = (cnt == CNT_MAX);

  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:   next_state = ST_IDLE;
      ST_IDLE: begin
        if (!coll_n)                           next_state = ST_HIT;
        else if (!left_n && right_n && !at_msb) next_state = ST_MOVE_L;
        else if (!right_n && left_n && !at_lsb) next_state = ST_MOVE_R;
      end
      ST_MOVE_L: next_state = ST_HOLD;
      ST_MOVE_R: next_state = ST_HOLD;
      ST_HOLD: begin
        // both buttons must be released so a held button moves only once
        if (!coll_n)                            next_state = ST_HIT;
        else if (cool_done && left_n && right_n) next_state = ST_IDLE;
      end
      ST_HIT:    next_state = (lives == 2'd0) ? ST_LOST : ST_HOLD;
      ST_LOST:   if (!start_n) next_state = ST_INIT;
      default:   next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) begin
      state <= ST_INIT;
      lives <= LIVES_RST;
      cnt   <= '0;
    end else begin
      state <= next_state;

      if (next_state == ST_HIT)
        lives <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
      else if (state == ST_LOST && next_state == ST_INIT)
        lives <= LIVES_RST;

      // held at zero outside HOLD, so every HOLD entry starts a fresh cooldown
      if (state != ST_HOLD)
        cnt <= '0;
      else if (!cool_done)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.SC_FrogMove_clear_OutLow       = (state != ST_INIT);
  assign bus.SC_FrogMove_load0_OutLow       = (state != ST_HIT);
  assign bus.SC_FrogMove_clearLOST_OutLow   = (state != ST_LOST);
  assign bus.SC_FrogMove_shiftselection_Out = (state == ST_MOVE_L) ? 2'b01 :
                                              (state == ST_MOVE_R) ? 2'b10 : 2'b00;
  assign bus.SC_FrogMove_lives_OutBUS       = lives;

endmodule

`default_nettype wire

// File: tb/tb_sc_statemachine_frogmove.sv
// ----------------------------------------------------------------------------
// tb_sc_statemachine_frogmove : scoreboard bench for the frog-move FSM.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sc_statemachine_frogmove;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sc_statemachine_frogmove_if #(.DATAWIDTH(8)) bus ();

  sc_statemachine_frogmove #(
    .DATAWIDTH       (8),
    .COOLDOWN_CYCLES (16),
    .LIVES_INIT      (3)
  ) dut (
    .SC_RegPOINTTYPE_CLOCK_50     (clk),
    .SC_RegPOINTTYPE_RESET_InHigh (rst),
    .bus                          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // output vector: {clear, load0, shift[1:0], clearLOST, lives[1:0]}
  function automatic logic [6:0] o_idle(input logic [1:0] l);
    return {1'b1, 1'b1, 2'b00, 1'b1, l};
  endfunction
  function automatic logic [6:0] o_init(input logic [1:0] l);
    return {1'b0, 1'b1, 2'b00, 1'b1, l};
  endfunction
  function automatic logic [6:0] o_ml(input logic [1:0] l);
    return {1'b1, 1'b1, 2'b01, 1'b1, l};
  endfunction
  function automatic logic [6:0] o_mr(input logic [1:0] l);
    return {1'b1, 1'b1, 2'b10, 1'b1, l};
  endfunction
  function automatic logic [6:0] o_hit(input logic [1:0] l);
    return {1'b1, 1'b0, 2'b00, 1'b1, l};
  endfunction
  function automatic logic [6:0] o_lost();
    return {1'b1, 1'b1, 2'b00, 1'b0, 2'b00};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b (clr,ld0,sh[1:0],clrLOST,lives[1:0])", tag, got, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    logic [6:0] got;
    e   = sb.pop_front();
    got = {bus.SC_FrogMove_clear_OutLow, bus.SC_FrogMove_load0_OutLow,
           bus.SC_FrogMove_shiftselection_Out, bus.SC_FrogMove_clearLOST_OutLow,
           bus.SC_FrogMove_lives_OutBUS};
    check(e.tag, got, e.exp);
  endtask

  task automatic expect_now(input string tag, input logic [6:0] e);
    sb.push_back('{tag, e});
    pop_compare();
  endtask

  task automatic step(input string tag, input logic s, input logic l, input logic r,
                      input logic c, input logic [6:0] e);
    @(negedge clk);
    bus.SC_FrogMove_start_InLow     = s;
    bus.SC_FrogMove_left_InLow      = l;
    bus.SC_FrogMove_right_InLow     = r;
    bus.SC_FrogMove_collision_InLow = c;
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  task automatic settle(input string tag, input logic [1:0] l);
    for (int i = 0; i < 17; i++) step(tag, 1'b1, 1'b1, 1'b1, 1'b1, o_idle(l));
  endtask

  initial begin
    bus.SC_FrogMove_start_InLow     = 1'b1;
    bus.SC_FrogMove_left_InLow      = 1'b1;
    bus.SC_FrogMove_right_InLow     = 1'b1;
    bus.SC_FrogMove_collision_InLow = 1'b1;
    bus.SC_FrogMove_frogPos_InBUS   = 8'b00001000;

    // reset and the single clear cycle
    #12;
    expect_now("reset_state", o_init(2'd3));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_now("init_to_idle", o_idle(2'd3));
    step("idle_quiet", 1, 1, 1, 1, o_idle(2'd3));

    // single pulse, re-pulse inside cooldown ignored
    bus.SC_FrogMove_frogPos_InBUS = 8'b00001000;
    step("move_left", 1, 0, 1, 1, o_ml(2'd3));
    for (int i = 1; i <= 17; i++)
      step("cooldown", 1, (i == 5) ? 1'b0 : 1'b1, 1, 1, o_idle(2'd3));
    step("move_left_after_cool", 1, 0, 1, 1, o_ml(2'd3));
    settle("settle1", 2'd3);

    // held button produces exactly one move
    bus.SC_FrogMove_frogPos_InBUS = 8'b00010000;
    for (int i = 0; i < 100; i++)
      step("held_left", 1, 0, 1, 1, (i == 0) ? o_ml(2'd3) : o_idle(2'd3));
    step("release", 1, 1, 1, 1, o_idle(2'd3));
    step("move_left_repress", 1, 0, 1, 1, o_ml(2'd3));
    settle("settle2", 2'd3);

    // edge guards, both buttons, right move, start ignored
    bus.SC_FrogMove_frogPos_InBUS = 8'b10000000;
    step("left_at_msb", 1, 0, 1, 1, o_idle(2'd3));
    step("quiet_msb", 1, 1, 1, 1, o_idle(2'd3));
    bus.SC_FrogMove_frogPos_InBUS = 8'b00000001;
    step("right_at_lsb", 1, 1, 0, 1, o_idle(2'd3));
    step("quiet_lsb", 1, 1, 1, 1, o_idle(2'd3));
    bus.SC_FrogMove_frogPos_InBUS = 8'b00001000;
    step("both_low", 1, 0, 0, 1, o_idle(2'd3));
    step("quiet_both", 1, 1, 1, 1, o_idle(2'd3));
    step("start_in_idle", 0, 1, 1, 1, o_idle(2'd3));
    step("move_right", 1, 1, 0, 1, o_mr(2'd3));
    settle("settle3", 2'd3);

    // three spaced collisions down to LOST
    for (int k = 0; k < 3; k++) begin
      step("hit", 1, 1, 1, 0, o_hit(2'(2 - k)));
      if (k < 2)
        for (int i = 0; i < 19; i++) step("after_hit", 1, 1, 1, 1, o_idle(2'(2 - k)));
    end
    for (int i = 0; i < 5; i++) step("lost", 1, 1, 1, 1, o_lost());
    step("lost_left", 1, 0, 1, 1, o_lost());
    step("lost_coll", 1, 1, 1, 0, o_lost());
    step("restart", 0, 1, 1, 1, o_init(2'd3));
    step("after_restart", 1, 1, 1, 1, o_idle(2'd3));

    // continuous collision: one life every two cycles
    step("chit0", 1, 1, 1, 0, o_hit(2'd2));
    step("chold0", 1, 1, 1, 0, o_idle(2'd2));
    step("chit1", 1, 1, 1, 0, o_hit(2'd1));
    step("chold1", 1, 1, 1, 0, o_idle(2'd1));
    step("chit2", 1, 1, 1, 0, o_hit(2'd0));
    step("clost", 1, 1, 1, 1, o_lost());
    step("restart2", 0, 1, 1, 1, o_init(2'd3));
    step("after_restart2", 1, 1, 1, 1, o_idle(2'd3));

    // reset during MOVE_L restores lives and aborts the shift
    step("hit_pre_rst", 1, 1, 1, 0, o_hit(2'd2));
    settle("settle4", 2'd2);
    step("move_pre_rst", 1, 0, 1, 1, o_ml(2'd2));
    bus.SC_FrogMove_left_InLow = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    expect_now("rst_mid_move", o_init(2'd3));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_now("rst_to_idle", o_idle(2'd3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
